// File: rtl/pll_lock_controller_if.sv
// Decision/status bundle between the frequency comparator side and the PLL lock sequencer.
// The master drives the loop enable and the decisions; the slave (the controller) returns the control word and status.
interface pll_lock_controller_if #(
    parameter int WIDTH = 8
);
    logic             Enable;
    logic             AdjValid;
    logic [1:0]       AdjustFreq;
    logic [WIDTH-1:0] FreqWord;
    logic             Locked;
    logic             LockLost;
    logic             CodeErr;
    logic [1:0]       State;

    modport master (
        output Enable, AdjValid, AdjustFreq,
        input  FreqWord, Locked, LockLost, CodeErr, State
    );

    modport slave (
        input  Enable, AdjValid, AdjustFreq,
        output FreqWord, Locked, LockLost, CodeErr, State
    );
endinterface

// File: rtl/pll_lock_controller.sv
// Coarse-acquire / fine-track / locked sequencer that turns comparator decisions
// into a saturating DCO frequency control word and reports lock status.
module pll_lock_controller #(
    parameter int WIDTH        = 8,
    parameter int INIT_WORD    = 128,
    parameter int COARSE_STEP  = 8,
    parameter int FINE_STEP    = 1,
    parameter int LOCK_COUNT   = 4,
    parameter int UNLOCK_COUNT = 2
) (
    input logic                    Clock,
    input logic                    Reset,
    pll_lock_controller_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ACQUIRE = 2'b01,
        TRACK   = 2'b10,
        LOCKED  = 2'b11
    } stateType;

    typedef enum logic [1:0] {
        DIR_NONE = 2'b00,
        DIR_UP   = 2'b01,
        DIR_DOWN = 2'b10
    } dirType;

    localparam logic [WIDTH-1:0] INIT_VAL    = WIDTH'(INIT_WORD);
    localparam logic [WIDTH:0]   COARSE_EXT  = (WIDTH+1)'(COARSE_STEP);
    localparam logic [WIDTH:0]   FINE_EXT    = (WIDTH+1)'(FINE_STEP);
    localparam logic [3:0]       LOCK_TH     = 4'(LOCK_COUNT);
    localparam logic [3:0]       UNLOCK_TH   = 4'(UNLOCK_COUNT);

    stateType         state, stateNext;
    dirType           lastDir, dirNext;
    logic [WIDTH-1:0] freqWord, wordNext;
    logic [3:0]       matchCnt, matchNext;
    logic [3:0]       missCnt, missNext;
    logic             locked, lockLost, lockLostNext, codeErr, codeErrNext;

    logic             isUp, isDown, isMatch;
    logic [WIDTH:0]   stepExt, sumUp, diffDown;
    logic [WIDTH-1:0] stepped;

    // Candidate stepped word, computed one bit wider so overflow/underflow clamp instead of wrapping
    always_comb begin
        isUp     = (bus.AdjustFreq == 2'b11);
        isDown   = (bus.AdjustFreq == 2'b00);
        isMatch  = bus.AdjustFreq[1] ^ bus.AdjustFreq[0];
        stepExt  = (state == ACQUIRE) ? COARSE_EXT : FINE_EXT;
        sumUp    = {1'b0, freqWord} + stepExt;
        diffDown = {1'b0, freqWord} - stepExt;
        stepped  = freqWord;
        if (isUp) begin
            stepped = sumUp[WIDTH] ? '1 : sumUp[WIDTH-1:0];
        end else if (isDown) begin
            stepped = diffDown[WIDTH] ? '0 : diffDown[WIDTH-1:0];
        end
    end

    always_comb begin
        stateNext    = state;
        wordNext     = freqWord;
        matchNext    = matchCnt;
        missNext     = missCnt;
        dirNext      = lastDir;
        lockLostNext = 1'b0;
        codeErrNext  = 1'b0;

        if (!bus.Enable) begin
            stateNext = IDLE;
            wordNext  = INIT_VAL;
            matchNext = '0;
            missNext  = '0;
            dirNext   = DIR_NONE;
        end else if (state == IDLE) begin
            stateNext = ACQUIRE;
        end else if (bus.AdjValid) begin
            codeErrNext = (bus.AdjustFreq == 2'b10);
            if (!isMatch) begin
                wordNext = stepped;
            end
            case (state)
                ACQUIRE: begin
                    // A reversal means we have bracketed the target, so hand over to fine tracking
                    if (isMatch ||
                        (isUp && lastDir == DIR_DOWN) ||
                        (isDown && lastDir == DIR_UP)) begin
                        stateNext = TRACK;
                        matchNext = '0;
                    end
                    if (!isMatch) begin
                        dirNext = isUp ? DIR_UP : DIR_DOWN;
                    end
                end
                TRACK: begin
                    if (!isMatch) begin
                        matchNext = '0;
                    end else if (matchCnt + 4'd1 >= LOCK_TH) begin
                        stateNext = LOCKED;
                        matchNext = LOCK_TH;
                        missNext  = '0;
                    end else begin
                        matchNext = matchCnt + 4'd1;
                    end
                end
                LOCKED: begin
                    if (isMatch) begin
                        missNext = '0;
                    end else if (missCnt + 4'd1 >= UNLOCK_TH) begin
                        stateNext    = TRACK;
                        matchNext    = '0;
                        missNext     = '0;
                        lockLostNext = 1'b1;
                    end else begin
                        missNext = missCnt + 4'd1;
                    end
                end
                default: stateNext = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state    <= IDLE;
            freqWord <= INIT_VAL;
            matchCnt <= '0;
            missCnt  <= '0;
            lastDir  <= DIR_NONE;
            locked   <= 1'b0;
            lockLost <= 1'b0;
            codeErr  <= 1'b0;
        end else begin
            state    <= stateNext;
            freqWord <= wordNext;
            matchCnt <= matchNext;
            missCnt  <= missNext;
            lastDir  <= dirNext;
            locked   <= (stateNext == LOCKED);
            lockLost <= lockLostNext;
            codeErr  <= codeErrNext;
        end
    end

    assign bus.FreqWord = freqWord;
    assign bus.Locked   = locked;
    assign bus.LockLost = lockLost;
    assign bus.CodeErr  = codeErr;
    assign bus.State    = state;

endmodule
